// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - three-cycle asynchronous SRAM controller with registered strobes
module sram_ctrl #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data2ram,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] data2fpga,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [DATA_WIDTH-1:0] sram_dq,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR1  = 3'd1,
      WR2  = 3'd2,
      RD1  = 3'd3,
      RD2  = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic                    ready_q, ready_d;
   logic                    ce_n_q, ce_n_d;
   logic                    oe_n_q, oe_n_d;
   logic                    we_n_q, we_n_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    drive_q, drive_d;

   // Every SRAM-facing signal comes straight from a flop so the pins never glitch.
   assign ready     = ready_q;
   assign data2fpga = rdata_q;
   assign sram_addr = addr_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_dq   = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

   // Next-state and next-output decode; each register holds unless its state changes it.
   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      ce_n_d  = ce_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      wdata_d = wdata_q;
      drive_d = drive_q;
      case (state_q)
         IDLE: begin
            // Request fields are captured only here, so busy-time traffic cannot leak in.
            if (mem) begin
               addr_d  = addr;
               wdata_d = data2ram;
               ready_d = 1'b0;
               ce_n_d  = 1'b0;
               if (rw) begin
                  oe_n_d  = 1'b0;
                  state_d = RD1;
               end else begin
                  drive_d = 1'b1;
                  state_d = WR1;
               end
            end
         end
         WR1: begin
            // Address and data have had a full cycle to settle before WE falls.
            we_n_d  = 1'b0;
            state_d = WR2;
         end
         WR2: begin
            // WE, CE and the bus release together, ending the write cleanly.
            we_n_d  = 1'b1;
            ce_n_d  = 1'b1;
            drive_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
         RD1: begin
            state_d = RD2;
         end
         RD2: begin
            // Two cycles of OE give the SRAM its access time before sampling.
            rdata_d = sram_dq;
            oe_n_d  = 1'b1;
            ce_n_d  = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            drive_d = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset forces strobes inactive and the bus released.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         addr_q  <= '0;
         rdata_q <= '0;
         wdata_q <= '0;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         wdata_q <= wdata_d;
         drive_q <= drive_d;
      end
   end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port asynchronous SRAM controller for the Mojo V3 external 8-bit SRAM. Accepts one read or write request at a time from an on-chip requester (`device_test`, video buffers) over the mem/rw/ready handshake and drives the SRAM address, data bus and CE/OE/WE strobes. Fixed three-cycle transaction, 60 ns at 50 MHz. All SRAM-side outputs are registered.

## Interface

Parameters:
- `ADDR_WIDTH`, 20: SRAM address width.
- `DATA_WIDTH`, 8: SRAM data width.

Ports:
- `clk` in 1: 50 MHz master clock; everything on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `mem` in 1: request strobe, level-sampled only while idle.
- `rw` in 1: request type, 1 = read, 0 = write; sampled with `mem`.
- `addr` in ADDR_WIDTH: request address; sampled with `mem`.
- `data2ram` in DATA_WIDTH: write data; sampled with `mem`.
- `ready` out 1: 1 = idle and able to accept; 0 = transaction in progress.
- `data2fpga` out DATA_WIDTH: last read data; holds until the next read completes.
- `sram_addr` out ADDR_WIDTH: SRAM address pins.
- `sram_dq` inout DATA_WIDTH: SRAM data bus. Tri-stated except during the write states.
- `sram_ce_n` out 1: chip enable, active-low.
- `sram_oe_n` out 1: output enable, active-low.
- `sram_we_n` out 1: write enable, active-low.

## Operation

- FSM states: IDLE, WR1, WR2, RD1, RD2.
- IDLE:
  - `ready`=1, all strobes high, bus released.
  - On an edge with `mem`=1:
    - Latch `addr`, `data2ram` and `rw`.
    - Set `ready`<=0 and `sram_ce_n`<=0.
    - Go to WR1 if `rw`=0, otherwise RD1.
- WR1 (address/data setup):
  - `sram_addr` = latched address; bus driven with latched data.
  - `sram_we_n`=1, `sram_oe_n`=1.
  - Next state: WR2.
- WR2 (write pulse):
  - `sram_we_n`=0, bus still driven.
  - Next state: IDLE. On that edge: `sram_we_n`<=1, `sram_ce_n`<=1, bus released, `ready`<=1.
- RD1 and RD2:
  - `sram_ce_n`=0, `sram_oe_n`=0, bus tri-stated.
  - RD1 goes to RD2.
  - RD2 goes to IDLE. On that edge: `data2fpga`<=`sram_dq`, `sram_oe_n`<=1, `sram_ce_n`<=1, `ready`<=1.
- Inputs are ignored outside IDLE. Requests made while busy are neither queued nor corrupted.
- `mem` is level-sensitive. If the requester holds `mem` high, a new transaction starts on the first IDLE edge.
- `sram_addr` holds its last value in IDLE.
- Write transactions never alter `data2fpga`.

## Timing

- Accept edge E0: the edge where the FSM is in IDLE and `mem`=1.
- `ready` is low from E0 to E2 and returns high at E2 (exactly 2 cycles low).
- Write:
  - Data is on the bus from E0 to E2.
  - `sram_we_n` is low from E1 to E2 (one 20 ns pulse, at least the 8 ns T_wp).
  - Address and data are stable for one full cycle before WE falls and until WE rises.
- Read:
  - `sram_oe_n` is low from E0 to E2, 40 ns of access time.
  - `data2fpga` is valid starting at E2, together with `ready` rising.
- Earliest next accept is E3, so sustained throughput is one transaction per 3 cycles.
- Reset values (`rst`=0 at an edge):
  - State IDLE, `ready`=1, `data2fpga`=0.
  - `sram_addr`=0; `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1; `sram_dq` high-Z.
- Reset mid-transaction:
  - Strobes go high and the bus is released at that same edge; the FSM goes to IDLE.
  - An aborted write leaves that SRAM location undefined.
  - An aborted read leaves `data2fpga`=0.
- `mem` and `rst` low on the same edge: reset wins and no transaction starts.
- Address range: 0x00000 to 0xFFFFF, no wrap handling; the full address is passed through.

## Test plan

- **Reset:** hold `rst`=0 for 2 cycles → `ready`=1, `data2fpga`=0x00, `sram_addr`=0x00000, CE/OE/WE=1, `sram_dq`=Z; release → still idle with `mem`=0.
- **Single write:** `mem`=1, `rw`=0, `addr`=0x00012, `data2ram`=0xA5 for one cycle → `ready` low for exactly 2 cycles; `sram_we_n` low for exactly 1 cycle, the second one; `sram_dq`=0xA5 whenever WE is low; SRAM model holds 0xA5 at 0x12.
- **Readback:** read 0x00012 → `data2fpga`=0xA5 on the same edge `ready` rises; `sram_we_n` stays 1 throughout; `sram_dq` never driven by the controller.
- **Busy masking:** during a write to 0xFFFFF with data 0x3C, pulse `mem`=1, `rw`=1, `addr`=0x00000 in WR1 → ignored; address 0xFFFFF written with 0x3C; the next `ready` is not followed by a read.
- **Back-to-back:** hold `mem`=1 and alternate write 0x5A/read at 0x00100 → a new accept every 3 cycles; the read returns 0x5A; `data2fpga` is unchanged by the writes.
- **Reset mid-transaction:** `rst`=0 at E1 of a read → at that edge OE/CE go to 1, `ready`=1, `data2fpga`=0x00; a following write/read of 0x77 behaves normally.
